// File: rtl/mrv32_pkg.sv
//==============================================================================
// Module      : mrv32_pkg
// Description : Shared bus constants, timer register map and byte-strobe merge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mrv32_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int WSTRB_WIDTH = 4;
    localparam logic [WSTRB_WIDTH-1:0] WSTRB_NONE = 4'b0000;

    typedef logic [4:0] tmr_off_t;

    localparam tmr_off_t TMR_MTIME_LO    = 5'h00;
    localparam tmr_off_t TMR_MTIME_HI    = 5'h04;
    localparam tmr_off_t TMR_MTIMECMP_LO = 5'h08;
    localparam tmr_off_t TMR_MTIMECMP_HI = 5'h0C;
    localparam tmr_off_t TMR_CTRL        = 5'h10;
    localparam tmr_off_t TMR_PRESCALE    = 5'h14;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    localparam logic [63:0] TMR_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0]            old_val,
        input logic [31:0]            wr_val,
        input logic [WSTRB_WIDTH-1:0] strb
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < WSTRB_WIDTH; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = wr_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mrv32_rsp_pipe.sv
//==============================================================================
// Module      : mrv32_rsp_pipe
// Description : Fixed-depth valid/data delay line for read responses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mrv32_rsp_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d;
    logic [WIDTH-1:0]            stage_in;

    // Data is zeroed on idle cycles so the output reads 0 whenever valid is low.
    assign stage_in = in_valid ? in_data : '0;

    generate
        if (DEPTH == 1) begin : g_single
            always_comb begin
                vld_d = in_valid;
                dat_d = stage_in;
            end
        end else begin : g_multi
            always_comb begin
                vld_d = {vld_q[DEPTH-2:0], in_valid};
                dat_d = {dat_q[DEPTH-2:0], stage_in};
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mrv32_mmio_timer.sv
//==============================================================================
// Module      : mrv32_mmio_timer
// Description : Memory-mapped 64-bit machine timer with compare interrupt.
//               Optional prescaler enabled by MRV32_TIMER_PRESCALE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mrv32_mmio_timer
    import mrv32_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int          RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   b_valid,
    input  logic [ADDR_WIDTH-1:0]  b_addr,
    input  logic [31:0]            b_wdata,
    input  logic [WSTRB_WIDTH-1:0] b_wstrb,
    output logic [31:0]            b_rdata,
    output logic                   b_rvalid,
    output logic                   timer_irq
);

    logic [63:0] mtime_q, mtime_d, mtime_nxt;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        irq_q, irq_d;

    logic        in_window, rd_en, wr_en, tick;
    tmr_off_t    reg_off;
    logic [31:0] rd_word, ctrl_merged, prescale_rd;
    logic        unused_addr_bits, unused_ctrl_hi;

    assign in_window = (b_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
    assign reg_off   = {b_addr[4:2], 2'b00};
    assign rd_en     = b_valid && (b_wstrb == WSTRB_NONE);
    assign wr_en     = b_valid && (b_wstrb != WSTRB_NONE) && in_window;

    assign ctrl_merged      = merge_bytes({30'h0, ctrl_q}, b_wdata, b_wstrb);
    assign unused_ctrl_hi   = ^ctrl_merged[31:2];
    assign unused_addr_bits = ^b_addr[1:0];

`ifdef MRV32_TIMER_PRESCALE_EN
    logic [15:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
    logic [31:0] prescale_merged;
    logic        unused_prescale_hi;

    assign prescale_merged    = merge_bytes({16'h0, prescale_q}, b_wdata, b_wstrb);
    assign unused_prescale_hi = ^prescale_merged[31:16];
    assign prescale_rd        = {16'h0, prescale_q};
    assign tick               = ctrl_q[CTRL_EN_BIT] && (pcnt_q == prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        if (ctrl_q[CTRL_EN_BIT]) begin
            pcnt_d = tick ? 16'h0 : pcnt_q + 16'h1;
        end
        // Reprogramming the divider restarts the count from zero.
        if (wr_en && (reg_off == TMR_PRESCALE)) begin
            prescale_d = prescale_merged[15:0];
            pcnt_d     = 16'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= 16'h0;
            pcnt_q     <= 16'h0;
        end else begin
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
        end
    end
`else
    assign prescale_rd = 32'h0;
    assign tick        = ctrl_q[CTRL_EN_BIT];
`endif

    // Written bytes override the incremented value; unwritten bytes keep counting.
    always_comb begin
        mtime_nxt  = tick ? (mtime_q + 64'd1) : mtime_q;
        mtime_d    = mtime_nxt;
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        shadow_d   = shadow_q;
        if (wr_en) begin
            case (reg_off)
                TMR_MTIME_LO:    mtime_d[31:0]     = merge_bytes(mtime_nxt[31:0], b_wdata, b_wstrb);
                TMR_MTIME_HI:    mtime_d[63:32]    = merge_bytes(mtime_nxt[63:32], b_wdata, b_wstrb);
                TMR_MTIMECMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], b_wdata, b_wstrb);
                TMR_MTIMECMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], b_wdata, b_wstrb);
                TMR_CTRL:        ctrl_d            = ctrl_merged[1:0];
                default:         ;
            endcase
        end
        if (rd_en && in_window && (reg_off == TMR_MTIME_LO)) begin
            shadow_d = mtime_q[63:32];
        end
    end

    always_comb begin
        rd_word = 32'h0;
        if (in_window) begin
            case (reg_off)
                TMR_MTIME_LO:    rd_word = mtime_q[31:0];
                TMR_MTIME_HI:    rd_word = shadow_q;
                TMR_MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
                TMR_MTIMECMP_HI: rd_word = mtimecmp_q[63:32];
                TMR_CTRL:        rd_word = {30'h0, ctrl_q};
                TMR_PRESCALE:    rd_word = prescale_rd;
                default:         rd_word = 32'h0;
            endcase
        end
    end

    assign irq_d = ctrl_q[CTRL_IRQ_EN_BIT] && (mtime_q >= mtimecmp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= 64'h0;
            mtimecmp_q <= TMR_MTIMECMP_RST;
            shadow_q   <= 32'h0;
            ctrl_q     <= 2'b00;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            shadow_q   <= shadow_d;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
        end
    end

    assign timer_irq = irq_q;

    mrv32_rsp_pipe #(
        .DEPTH (RD_LATENCY),
        .WIDTH (32)
    ) u_rsp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_en),
        .in_data   (rd_word),
        .out_valid (b_rvalid),
        .out_data  (b_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_mrv32_mmio_timer.sv
//==============================================================================
// Module      : tb_mrv32_mmio_timer
// Description : Self-checking bench for mrv32_mmio_timer against a
//               transaction-level model of the timer register map.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mrv32_mmio_timer;
    import mrv32_pkg::*;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          LAT  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        b_valid;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_wstrb;
    logic        b_rvalid, timer_irq;

    always #5 clk = ~clk;

    mrv32_mmio_timer #(
        .BASE_ADDR  (BASE),
        .RD_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_wstrb   (b_wstrb),
        .b_rdata   (b_rdata),
        .b_rvalid  (b_rvalid),
        .timer_irq (timer_irq)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_shadow;
    logic        m_en, m_irqen, m_irq;
    logic [15:0] m_pre, m_pcnt;
    typedef struct {int due; logic [31:0] data;} rsp_t;
    rsp_t        m_q[$];
    logic        exp_rvalid;
    logic [31:0] exp_rdata;

    function automatic logic [31:0] bmerge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < BASE || a > BASE + 32'd31) return 32'h0;
        case (a[4:2])
            3'd0: return m_mtime[31:0];
            3'd1: return m_shadow;
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {30'h0, m_irqen, m_en};
`ifdef MRV32_TIMER_PRESCALE_EN
            3'd5: return {16'h0, m_pre};
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mtime = 64'h0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = 32'h0;
        m_en = 1'b0; m_irqen = 1'b0; m_irq = 1'b0; m_pre = 16'h0; m_pcnt = 16'h0;
        m_q.delete();
        exp_rvalid = 1'b0; exp_rdata = 32'h0;
    endtask

    // Drive one bus cycle, advance the model by the same clock edge, settle.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic        tick, win, rd, wr;
        logic [63:0] nt;
        logic [31:0] tmp;
        b_valid = v; b_addr = a; b_wdata = d; b_wstrb = s;
        @(posedge clk);
        cyc++;
        win = (a >= BASE) && (a <= BASE + 32'd31);
        rd  = v && (s == 4'b0000);
        wr  = v && (s != 4'b0000) && win;
`ifdef MRV32_TIMER_PRESCALE_EN
        tick = m_en && (m_pcnt == m_pre);
        if (m_en) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
`else
        tick = m_en;
`endif
        if (rd) m_q.push_back('{cyc + LAT - 1, model_read(a)});
        if (rd && win && a[4:2] == 3'd0) m_shadow = m_mtime[63:32];
        m_irq = m_irqen && (m_mtime >= m_cmp);
        nt = m_mtime + (tick ? 64'd1 : 64'd0);
        if (wr) begin
            case (a[4:2])
                3'd0: nt[31:0]     = bmerge(nt[31:0], d, s);
                3'd1: nt[63:32]    = bmerge(nt[63:32], d, s);
                3'd2: m_cmp[31:0]  = bmerge(m_cmp[31:0], d, s);
                3'd3: m_cmp[63:32] = bmerge(m_cmp[63:32], d, s);
                3'd4: if (s[0]) begin m_en = d[0]; m_irqen = d[1]; end
`ifdef MRV32_TIMER_PRESCALE_EN
                3'd5: begin
                    tmp    = bmerge({16'h0, m_pre}, d, s);
                    m_pre  = tmp[15:0];
                    m_pcnt = 16'd0;
                end
`endif
                default: ;
            endcase
        end
        m_mtime = nt;
        exp_rvalid = 1'b0; exp_rdata = 32'h0;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            exp_rvalid = 1'b1;
            exp_rdata  = m_q[0].data;
            void'(m_q.pop_front());
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic apply_reset(input int n);
        #2;
        rst_n = 1'b0; b_valid = 1'b0; b_wstrb = 4'h0;
        model_reset();
        repeat (n) begin @(posedge clk); #1; end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] tbl [8];
        int n;
        tbl = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        rst_n = 1'b0; b_valid = 1'b0; b_addr = 32'h0; b_wdata = 32'h0; b_wstrb = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (b_rvalid !== 1'b0 || b_rdata !== 32'h0 || timer_irq !== 1'b0)
            $display("FAIL reset_outputs: got rvalid=%b rdata=%h irq=%b required 0/0/0", b_rvalid, b_rdata, timer_irq);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, BASE + 32'(i * 4), 32'h0, 4'h0);
            n = 1;
            while (!b_rvalid && n < 10) begin idle(); n++; end
            checks++;
            if (!b_rvalid || b_rdata !== tbl[i]) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h (rvalid=%b) required %h", i, b_rdata, b_rvalid, tbl[i]);
            end
        end
    endtask

    task automatic test_byte_write();
        int n;
        step(1'b1, BASE + 32'h08, 32'h00AB_0000, 4'b0100);
        step(1'b1, BASE + 32'h08, 32'h0, 4'h0);
        n = 1;
        while (!b_rvalid && n < 10) begin idle(); n++; end
        checks++;
        if (!b_rvalid || b_rdata !== 32'hFFAB_FFFF) begin
            errors++;
            $display("FAIL byte_write: got %h required ffabffff", b_rdata);
        end
    endtask

    task automatic test_count();
        int n;
        apply_reset(2);
        step(1'b1, BASE + 32'h10, 32'h1, 4'hF);
        repeat (10) idle();
        step(1'b1, BASE, 32'h0, 4'h0);
        n = 1;
        while (!b_rvalid && n < 10) begin idle(); n++; end
        checks++;
        if (!b_rvalid || n != LAT) begin
            errors++;
            $display("FAIL count_latency: got %0d cycles required %0d", n, LAT);
        end
        checks++;
        if (b_rdata !== exp_rdata || b_rdata < 32'd10 || b_rdata > 32'd12) begin
            errors++;
            $display("FAIL count_value: got %0d required %0d", b_rdata, exp_rdata);
        end
    endtask

    task automatic test_shadow();
        logic [31:0] got [4];
        int k;
        apply_reset(2);
        k = 0;
        step(1'b1, BASE + 32'h00, 32'hFFFF_FFFE, 4'hF);
        step(1'b1, BASE + 32'h04, 32'h0, 4'hF);
        step(1'b1, BASE + 32'h10, 32'h1, 4'hF);
        repeat (3) idle();
        step(1'b1, BASE + 32'h00, 32'h0, 4'h0);
        if (b_rvalid && k < 4) begin got[k] = b_rdata; k++; end
        step(1'b1, BASE + 32'h04, 32'h0, 4'h0);
        if (b_rvalid && k < 4) begin got[k] = b_rdata; k++; end
        repeat (LAT + 1) begin
            idle();
            if (b_rvalid && k < 4) begin got[k] = b_rdata; k++; end
        end
        checks++;
        if (k != 2 || got[0] !== 32'h1 || got[1] !== 32'h1) begin
            errors++;
            $display("FAIL shadow: got n=%0d lo=%h hi=%h required n=2 lo=1 hi=1", k, got[0], got[1]);
        end
    endtask

    task automatic test_irq();
        int n;
        apply_reset(2);
        step(1'b1, BASE + 32'h0C, 32'h0, 4'hF);
        step(1'b1, BASE + 32'h08, 32'd20, 4'hF);
        step(1'b1, BASE + 32'h10, 32'h3, 4'hF);
        n = 0;
        while (!timer_irq && n < 40) begin
            idle(); n++;
            checks++;
            if (timer_irq !== m_irq) begin
                errors++;
                $display("FAIL irq_track: got %b required %b at step %0d", timer_irq, m_irq, n);
            end
        end
        checks++;
        if (n != 21) begin
            errors++;
            $display("FAIL irq_rise: got %0d cycles required 21", n);
        end
        step(1'b1, BASE + 32'h08, 32'd100, 4'hF);
        checks++;
        if (timer_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_hold: got %b required 1", timer_irq);
        end
        idle();
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall: got %b required 0", timer_irq);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got [4];
        int          pos [4];
        int k;
        apply_reset(2);
        step(1'b1, BASE + 32'h10, 32'h1, 4'hF);
        k = 0;
        for (int i = 0; i < 3 + LAT + 1; i++) begin
            case (i)
                0: step(1'b1, BASE + 32'h00, 32'h0, 4'h0);
                1: step(1'b1, BASE + 32'h10, 32'h0, 4'h0);
                2: step(1'b1, BASE + 32'h40, 32'h0, 4'h0);
                default: idle();
            endcase
            checks++;
            if (b_rvalid !== exp_rvalid || b_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL b2b_rsp: got %b/%h required %b/%h", b_rvalid, b_rdata, exp_rvalid, exp_rdata);
            end
            if (b_rvalid && k < 4) begin got[k] = b_rdata; pos[k] = i; k++; end
        end
        checks++;
        if (k != 3 || pos[1] != pos[0] + 1 || pos[2] != pos[1] + 1 || got[1] !== 32'h1 || got[2] !== 32'h0) begin
            errors++;
            $display("FAIL b2b_order: got n=%0d ctrl=%h third=%h required 3 pulses ctrl=1 third=0", k, got[1], got[2]);
        end
        step(1'b1, BASE, 32'h0, 4'h0);
        apply_reset(2);
        for (int i = 0; i < LAT + 3; i++) begin
            idle();
            checks++;
            if (b_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush: got rvalid=%b required 0 at cycle %0d", b_rvalid, i);
            end
        end
    endtask

    task automatic test_random();
        logic        v;
        logic [31:0] a, d;
        logic [3:0]  s;
        apply_reset(2);
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            d = $urandom;
            if (a[4:2] == 3'd1 && s != 4'h0) d = $urandom_range(0, 3);
            step(v, a, d, s);
            checks++;
            if (b_rvalid !== exp_rvalid || b_rdata !== exp_rdata || timer_irq !== m_irq) begin
                errors++;
                $display("FAIL random_%0d: got rv=%b rd=%h irq=%b required rv=%b rd=%h irq=%b",
                         i, b_rvalid, b_rdata, timer_irq, exp_rvalid, exp_rdata, m_irq);
            end
        end
    endtask

`ifdef MRV32_TIMER_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] got [4];
        int k;
        apply_reset(2);
        step(1'b1, BASE + 32'h14, 32'd3, 4'hF);
        step(1'b1, BASE + 32'h10, 32'h1, 4'hF);
        repeat (5) idle();
        k = 0;
        for (int i = 0; i < 40 + LAT + 1; i++) begin
            if (i == 0 || i == 40) step(1'b1, BASE, 32'h0, 4'h0);
            else idle();
            if (b_rvalid && k < 4) begin got[k] = b_rdata; k++; end
        end
        checks++;
        if (k != 2 || (got[1] - got[0]) !== 32'd10) begin
            errors++;
            $display("FAIL prescale: got n=%0d delta=%0d required 2 reads delta=10", k, got[1] - got[0]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_byte_write();
        test_count();
        test_shadow();
        test_irq();
        test_back_to_back();
        test_random();
`ifdef MRV32_TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mrv32_mmio_timer.md
MRV32_MMIO_TIMER -- requirements
Module: mrv32_mmio_timer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0001_0000, meaning the byte base of the 32-byte register window (aligned to 32).
REQ-002 The block SHALL have parameter RD_LATENCY, default 1, meaning the fixed request-to-rvalid delay in cycles (legal 1..4).
REQ-003 clk  input  1  clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 b_valid  input  1  request strobe; one request per cycle with b_valid=1.
REQ-006 b_addr  input  ADDR_WIDTH  byte address; only the word address b_addr[ADDR_WIDTH-1:2] is used.
REQ-007 b_wdata  input  32  lane-positioned write data.
REQ-008 b_wstrb  input  4  byte enables; 4'b0000 = read, nonzero = write.
REQ-009 b_rdata  output  32  read data, valid only while b_rvalid=1, else 0.
REQ-010 b_rvalid  output  1  one-cycle read-response pulse.
REQ-011 timer_irq  output  1  registered machine-timer interrupt level.

Function
REQ-012 The register map SHALL be: +0x00 MTIME_LO, +0x04 MTIME_HI (read: shadow), +0x08 MTIMECMP_LO, +0x0C MTIMECMP_HI, +0x10 CTRL (bit0 EN, bit1 IRQ_EN, other bits read 0), +0x14 PRESCALE (macro only, REQ-025); all other offsets SHALL be reserved (read 0, writes ignored).
REQ-013 Requests with b_addr outside [BASE_ADDR, BASE_ADDR+31] SHALL be accepted: reads respond with data 0 at normal latency, and writes are ignored.
REQ-014 Writes SHALL produce no response and SHALL update only the bytes whose b_wstrb bit is 1, effective on the clock edge that samples b_valid.
REQ-015 Every read SHALL produce exactly one b_rvalid pulse exactly RD_LATENCY cycles after the sampling edge; b_rdata SHALL be the register value captured at that edge, carried through a RD_LATENCY-deep valid/data shift pipeline.
REQ-016 Back-to-back reads on consecutive cycles SHALL be fully pipelined, with responses in request order and no stalls; no backpressure exists.
REQ-017 When CTRL.EN=1, the 64-bit mtime SHALL increment by 1 per tick and wrap from 2^64-1 to 0, with the carry from LO into HI occurring in the same cycle.
REQ-018 A tick SHALL be every cycle without the macro, or per REQ-025 with it.
REQ-019 If a write to MTIME_LO or MTIME_HI coincides with a tick, written bytes SHALL take the write value, and unwritten bytes SHALL take the incremented value for that cycle.
REQ-020 A read of MTIME_LO SHALL capture the current MTIME_HI into a shadow register in the same cycle; reads of +0x04 SHALL return the shadow, giving a coherent LO-then-HI 64-bit read.
REQ-021 timer_irq SHALL be registered and equal CTRL.IRQ_EN && (mtime >= mtimecmp, unsigned 64-bit), evaluated on pre-update register values, so it is 1 cycle late.
REQ-022 A write to MTIMECMP that makes mtimecmp > mtime SHALL deassert timer_irq on the following cycle.

Reset
REQ-023 While rst_n=0, the block SHALL hold mtime=0, shadow=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESCALE=0, prescale counter=0, the response pipeline empty, b_rvalid=0, b_rdata=0, and timer_irq=0.
REQ-024 When reset asserts mid-operation, the block SHALL drop any in-flight read responses with no late b_rvalid after release.

Configuration
REQ-025 With MRV32_TIMER_PRESCALE_EN defined, PRESCALE at +0x14 SHALL be a read/write register (bits[15:0], upper bits read 0); an internal 16-bit counter SHALL count 0..PRESCALE, a tick SHALL occur when the counter equals PRESCALE, and the counter SHALL then return to 0; PRESCALE=0 SHALL tick every cycle; writing PRESCALE SHALL clear the counter.
REQ-026 Without MRV32_TIMER_PRESCALE_EN, +0x14 SHALL be reserved, no prescale logic SHALL exist, and mtime SHALL tick every cycle while EN=1.

Structure
REQ-027 Register offset constants (TMR_MTIME_LO..TMR_PRESCALE), CTRL bit indices, and the 64-bit mtimecmp reset value SHALL live in mrv32_pkg, alongside existing ADDR_WIDTH and WSTRB_* constants.
REQ-028 The byte-strobe merge function SHALL be shared in the package and reused for all registers.
REQ-029 The response delay line SHALL be a sub-module mrv32_rsp_pipe, parameterised by DEPTH (=RD_LATENCY) and width 32, with valid and data outputs.

Verification
REQ-030 The bench SHALL cover: write CTRL=0x1, wait 10 cycles, read MTIME_LO -> rvalid exactly RD_LATENCY cycles later, data 10 +/- the fixed pipeline offset, checked against the model.
REQ-031 The bench SHALL cover: write MTIME_LO=0xFFFF_FFFE, MTIME_HI=0, EN=1, wait 3 ticks, read LO then HI -> LO=0x0000_0001, HI=0x0000_0001 (shadow coherent).
REQ-032 The bench SHALL cover: byte write wstrb=4'b0100, wdata=0x00AB_0000 to MTIMECMP_LO after reset -> read returns 0xFFAB_FFFF.
REQ-033 The bench SHALL cover: mtimecmp=20, CTRL=0x3 -> timer_irq rises one cycle after mtime reaches 20; writing MTIMECMP_LO=100 -> irq falls the next cycle.
REQ-034 The bench SHALL cover: three consecutive reads (MTIME_LO, CTRL, address BASE_ADDR+0x40) -> three in-order rvalid pulses on consecutive cycles, third data=0; assert rst_n=0 with a read in flight -> no rvalid after release.
REQ-035 The bench SHALL cover, with MRV32_TIMER_PRESCALE_EN: PRESCALE=3, EN=1, run 40 cycles -> mtime advances by 10.
